cam_hw_scoreboard: RTL and testbench

//  Synthesisable, parametrised CAM scoreboard. It holds its own golden copy of a

---
 rtl/cam_hw_scoreboard_if.sv | 25 ++
 rtl/cam_hw_scoreboard.sv | 229 ++++++++++++++++++++++
 tb/tb_cam_hw_scoreboard.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_hw_scoreboard_if.sv
// rtl/cam_hw_scoreboard_if.sv - transaction bus from the CAM bus monitor into the scoreboard
interface cam_hw_scoreboard_if #(
    parameter int KEY_W   = 16,
    parameter int DATA_W  = 32,
    parameter int LTIME_W = 32
);
    logic               tr_valid;
    logic               tr_ready;
    logic [1:0]         tr_type;
    logic [KEY_W-1:0]   tr_key;
    logic [DATA_W-1:0]  tr_wdata;
    logic [DATA_W-1:0]  tr_rdata;
    logic               tr_hit;
    logic [LTIME_W-1:0] tr_ltime;

    modport master (
        output tr_valid, tr_type, tr_key, tr_wdata, tr_rdata, tr_hit, tr_ltime,
        input  tr_ready
    );

    modport slave (
        input  tr_valid, tr_type, tr_key, tr_wdata, tr_rdata, tr_hit, tr_ltime,
        output tr_ready
    );
endinterface

// File: rtl/cam_hw_scoreboard.sv
// rtl/cam_hw_scoreboard.sv - hardware scoreboard with a golden true-LRU CAM model, coverage and error counting
module cam_hw_scoreboard #(
    parameter int KEY_W    = 16,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int LTIME_W  = 32,
    parameter int ERRCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    cam_hw_scoreboard_if.slave  bus,
    output logic                chk_valid,
    output logic                chk_err,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [DEPTH-1:0]    cov_hits,
    output logic [DEPTH-1:0]    cov_evicts,
    output logic                cov_ww,
    output logic                cov_wr
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] TY_RESET = 2'd0;
    localparam logic [1:0] TY_READ  = 2'd1;
    localparam logic [1:0] TY_WRITE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_COMMIT
    } state_t;

    state_t state, next_state;

    logic [1:0]         l_type;
    logic [KEY_W-1:0]   l_key;
    logic [DATA_W-1:0]  l_wdata;
    logic [DATA_W-1:0]  l_rdata;
    logic               l_hit;
    logic [LTIME_W-1:0] l_ltime;

    logic               ent_valid [DEPTH];
    logic [KEY_W-1:0]   ent_key   [DEPTH];
    logic [DATA_W-1:0]  ent_data  [DEPTH];
    logic [IDX_W-1:0]   ent_age   [DEPTH];

    logic               hit_found, free_found;
    logic [IDX_W-1:0]   hit_idx, free_idx, victim_idx;

    logic               lk_hit, lk_free;
    logic [IDX_W-1:0]   lk_hit_idx, lk_free_idx, lk_victim_idx;
    logic [DATA_W-1:0]  lk_data;

    logic               prev_valid;
    logic [1:0]         prev_type;
    logic [KEY_W-1:0]   prev_key;
    logic [DATA_W-1:0]  prev_wdata;
    logic [LTIME_W-1:0] prev_ltime;

    logic               commit;
    logic               touch_en, evict_en, err_raw, b2b;
    logic [IDX_W-1:0]   touch_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        bus.tr_ready = 1'b0;
        chk_valid    = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.tr_ready = 1'b1;
                if (bus.tr_valid) begin
                    next_state = ST_LOOKUP;
                end
            end
            ST_LOOKUP: next_state = ST_COMMIT;
            ST_COMMIT: begin
                chk_valid  = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign commit = (state == ST_COMMIT);

    always_ff @(posedge clk) begin
        if (bus.tr_valid && bus.tr_ready) begin
            l_type  <= bus.tr_type;
            l_key   <= bus.tr_key;
            l_wdata <= bus.tr_wdata;
            l_rdata <= bus.tr_rdata;
            l_hit   <= bus.tr_hit;
            l_ltime <= bus.tr_ltime;
        end
    end

    // Descending scan so the lowest matching/free index is the one that sticks.
    always_comb begin
        hit_found  = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        victim_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_key[i] == l_key)) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(i);
            end
            if (!ent_valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ent_age[i] == IDX_W'(DEPTH - 1)) begin
                victim_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_LOOKUP) begin
            lk_hit        <= hit_found;
            lk_hit_idx    <= hit_idx;
            lk_free       <= free_found;
            lk_free_idx   <= free_idx;
            lk_victim_idx <= victim_idx;
            lk_data       <= ent_data[hit_idx];
        end
    end

    always_comb begin
        touch_en  = 1'b0;
        evict_en  = 1'b0;
        touch_idx = lk_hit_idx;
        err_raw   = 1'b0;
        case (l_type)
            TY_RESET: err_raw = 1'b0;
            TY_READ: begin
                touch_en = lk_hit;
                err_raw  = lk_hit ? (!l_hit || (l_rdata != lk_data)) : l_hit;
            end
            TY_WRITE: begin
                touch_en = 1'b1;
                if (!lk_hit) begin
                    touch_idx = lk_free ? lk_free_idx : lk_victim_idx;
                    evict_en  = !lk_free;
                end
            end
            default: err_raw = 1'b1;
        endcase
    end

    assign chk_err = chk_valid && err_raw;

    assign b2b = prev_valid && (prev_type == TY_WRITE)
                 && ((prev_ltime + LTIME_W'(1)) == l_ltime);

    // Touching entry t ages everything younger than t by one; t becomes youngest.
    always_ff @(posedge clk) begin
        if (rst || (commit && (l_type == TY_RESET))) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid[i] <= 1'b0;
                ent_age[i]   <= IDX_W'(i);
            end
        end else if (commit && touch_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_age[i] < ent_age[touch_idx]) begin
                    ent_age[i] <= ent_age[i] + 1'b1;
                end
            end
            ent_age[touch_idx] <= '0;
            if (l_type == TY_WRITE) begin
                ent_valid[touch_idx] <= 1'b1;
                ent_key[touch_idx]   <= l_key;
                ent_data[touch_idx]  <= l_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count  <= '0;
            cov_hits   <= '0;
            cov_evicts <= '0;
            cov_ww     <= 1'b0;
            cov_wr     <= 1'b0;
        end else if (commit) begin
            if (err_raw && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
            if ((l_type == TY_READ) && lk_hit) begin
                cov_hits[lk_hit_idx] <= 1'b1;
            end
            if (evict_en) begin
                cov_evicts[lk_victim_idx] <= 1'b1;
            end
            if (b2b && (prev_key == l_key)) begin
                if ((l_type == TY_WRITE) && (prev_wdata != l_wdata)) begin
                    cov_ww <= 1'b1;
                end
                if (l_type == TY_READ) begin
                    cov_wr <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
            prev_type  <= TY_RESET;
            prev_key   <= '0;
            prev_wdata <= '0;
            prev_ltime <= '0;
        end else if (commit) begin
            prev_valid <= 1'b1;
            prev_type  <= l_type;
            prev_key   <= l_key;
            prev_wdata <= l_wdata;
            prev_ltime <= l_ltime;
        end
    end
endmodule

// File: tb/tb_cam_hw_scoreboard.sv
// tb/tb_cam_hw_scoreboard.sv - directed and randomized bench for cam_hw_scoreboard against a queue-based LRU model
module tb_cam_hw_scoreboard;
    localparam int KEY_W    = 16;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 8;
    localparam int LTIME_W  = 32;
    localparam int ERRCNT_W = 4;
    localparam int ERR_MAX  = (1 << ERRCNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                chk_valid, chk_err;
    logic [ERRCNT_W-1:0] err_count;
    logic [DEPTH-1:0]    cov_hits, cov_evicts;
    logic                cov_ww, cov_wr;

    always #5 clk = ~clk;

    cam_hw_scoreboard_if #(.KEY_W(KEY_W), .DATA_W(DATA_W), .LTIME_W(LTIME_W)) bus ();

    cam_hw_scoreboard #(
        .KEY_W(KEY_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LTIME_W(LTIME_W), .ERRCNT_W(ERRCNT_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .chk_valid(chk_valid), .chk_err(chk_err), .err_count(err_count),
        .cov_hits(cov_hits), .cov_evicts(cov_evicts), .cov_ww(cov_ww), .cov_wr(cov_wr)
    );

    // Reference CAM: entries plus a recency list, most recently used first.
    bit                 m_valid [DEPTH];
    logic [KEY_W-1:0]   m_key   [DEPTH];
    logic [DATA_W-1:0]  m_data  [DEPTH];
    int                 lru[$];
    logic [DEPTH-1:0]   m_hits, m_evicts;
    bit                 m_ww, m_wr;
    int                 m_errs;
    bit                 p_valid;
    logic [1:0]         p_type;
    logic [KEY_W-1:0]   p_key;
    logic [DATA_W-1:0]  p_wdata;
    logic [LTIME_W-1:0] p_ltime;

    int                 checks = 0;
    int                 failures = 0;
    logic [LTIME_W-1:0] lt;
    logic               last_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear_cam();
        lru.delete();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            lru.push_back(i);
        end
    endfunction

    function automatic void model_reset_all();
        model_clear_cam();
        m_hits = '0; m_evicts = '0; m_ww = 1'b0; m_wr = 1'b0; m_errs = 0; p_valid = 1'b0;
    endfunction

    function automatic int find_key(input logic [KEY_W-1:0] k);
        for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_key[i] == k) return i;
        return -1;
    endfunction

    function automatic int find_free();
        for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic void touch(input int t);
        for (int j = 0; j < lru.size(); j++) begin
            if (lru[j] == t) begin
                lru.delete(j);
                break;
            end
        end
        lru.push_front(t);
    endfunction

    task automatic model_step(input logic [1:0] ty, input logic [KEY_W-1:0] k,
                              input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd,
                              input logic h, input logic [LTIME_W-1:0] t_in, output logic err);
        int idx;
        bit b2b;
        err = 1'b0;
        b2b = p_valid && (p_type == 2'd2) && ((p_ltime + LTIME_W'(1)) == t_in);
        idx = find_key(k);
        case (ty)
            2'd0: model_clear_cam();
            2'd1: begin
                if (idx >= 0) begin
                    err = !h || (rd != m_data[idx]);
                    m_hits[idx] = 1'b1;
                    touch(idx);
                end else begin
                    err = h;
                end
                if (b2b && p_key == k) m_wr = 1'b1;
            end
            2'd2: begin
                if (idx < 0) begin
                    idx = find_free();
                    if (idx < 0) begin
                        idx = lru[$];
                        m_evicts[idx] = 1'b1;
                    end
                    m_valid[idx] = 1'b1;
                    m_key[idx] = k;
                end
                m_data[idx] = wd;
                touch(idx);
                if (b2b && p_key == k && p_wdata != wd) m_ww = 1'b1;
            end
            default: err = 1'b1;
        endcase
        if (err) m_errs++;
        p_valid = 1'b1; p_type = ty; p_key = k; p_wdata = wd; p_ltime = t_in;
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_ready"}, 64'(bus.tr_ready), 64'(1));
        check({tag, "_err_count"}, 64'(err_count), 64'(m_errs > ERR_MAX ? ERR_MAX : m_errs));
        check({tag, "_cov_hits"}, 64'(cov_hits), 64'(m_hits));
        check({tag, "_cov_evicts"}, 64'(cov_evicts), 64'(m_evicts));
        check({tag, "_cov_ww"}, 64'(cov_ww), 64'(m_ww));
        check({tag, "_cov_wr"}, 64'(cov_wr), 64'(m_wr));
    endtask

    // Called at a negedge; returns at the negedge of the cycle after commit.
    task automatic do_tr(input logic [1:0] ty, input logic [KEY_W-1:0] k,
                         input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd,
                         input logic h, input logic [LTIME_W-1:0] t_in);
        int n;
        logic exp_err;
        n = 0;
        while (!bus.tr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 64'(bus.tr_ready), 64'(1));
        bus.tr_valid = 1'b1; bus.tr_type = ty; bus.tr_key = k;
        bus.tr_wdata = wd; bus.tr_rdata = rd; bus.tr_hit = h; bus.tr_ltime = t_in;
        model_step(ty, k, wd, rd, h, t_in, exp_err);
        @(negedge clk);
        bus.tr_valid = 1'b0;
        bus.tr_type = 2'($urandom); bus.tr_key = KEY_W'($urandom);
        bus.tr_rdata = $urandom; bus.tr_wdata = $urandom; bus.tr_hit = 1'($urandom);
        check("lookup_chk_valid", 64'(chk_valid), 64'(0));
        check("lookup_ready", 64'(bus.tr_ready), 64'(0));
        @(negedge clk);
        check("commit_chk_valid", 64'(chk_valid), 64'(1));
        check("commit_chk_err", 64'(chk_err), 64'(exp_err));
        last_err = chk_err;
        @(negedge clk);
        check_idle_state("post");
    endtask

    task automatic tx(input logic [1:0] ty, input logic [KEY_W-1:0] k,
                      input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd, input logic h);
        lt = lt + LTIME_W'(1);
        do_tr(ty, k, wd, rd, h, lt);
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        bus.tr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset_all();
        lt = LTIME_W'(1000);
        check("rst_chk_valid", 64'(chk_valid), 64'(0));
        check("rst_chk_err", 64'(chk_err), 64'(0));
        check_idle_state("rst");
    endtask

    initial begin
        int idx;
        logic [1:0] ty;
        logic [KEY_W-1:0] k;
        logic [DATA_W-1:0] rd;
        logic h;
        rst = 1'b1;
        bus.tr_valid = 1'b0; bus.tr_type = '0; bus.tr_key = '0; bus.tr_wdata = '0;
        bus.tr_rdata = '0; bus.tr_hit = 1'b0; bus.tr_ltime = '0;
        lt = '0;

        hard_reset();
        tx(2'd1, 16'h0001, 32'h0, 32'h0, 1'b0);
        check("t1_miss_ok", 64'(last_err), 64'(0));
        tx(2'd1, 16'h0001, 32'h0, 32'h0, 1'b1);
        check("t1_miss_err", 64'(last_err), 64'(1));
        check("t1_err_count", 64'(err_count), 64'(1));

        hard_reset();
        tx(2'd2, 16'h0010, 32'hA5A5A5A5, 32'h0, 1'b0);
        tx(2'd1, 16'h0010, 32'h0, 32'hA5A5A5A5, 1'b1);
        check("t2_hit_ok", 64'(last_err), 64'(0));
        check("t2_cov_hits0", 64'(cov_hits[0]), 64'(1));
        tx(2'd1, 16'h0010, 32'h0, 32'hA5A5A5A4, 1'b1);
        check("t2_bad_data", 64'(last_err), 64'(1));

        hard_reset();
        for (int i = 0; i <= 8; i++) tx(2'd2, KEY_W'(i), DATA_W'(32'h1000 + i), 32'h0, 1'b0);
        check("t3_evicts", 64'(cov_evicts), 64'(8'h01));
        tx(2'd1, 16'h0000, 32'h0, 32'h0, 1'b0);
        check("t3_key0_gone", 64'(last_err), 64'(0));

        hard_reset();
        for (int i = 0; i < 8; i++) tx(2'd2, KEY_W'(i), DATA_W'(32'h1000 + i), 32'h0, 1'b0);
        tx(2'd1, 16'h0000, 32'h0, 32'h1000, 1'b1);
        tx(2'd2, 16'h0008, 32'h1008, 32'h0, 1'b0);
        check("t4_evicts", 64'(cov_evicts), 64'(8'h02));
        tx(2'd1, 16'h0000, 32'h0, 32'h1000, 1'b1);
        check("t4_key0_hits", 64'(last_err), 64'(0));

        hard_reset();
        do_tr(2'd2, 16'h0007, 32'h1, 32'h0, 1'b0, 32'd10);
        do_tr(2'd1, 16'h0007, 32'h0, 32'h1, 1'b1, 32'd12);
        do_tr(2'd2, 16'h0007, 32'h3, 32'h0, 1'b0, 32'd30);
        do_tr(2'd2, 16'h0007, 32'h4, 32'h0, 1'b0, 32'd32);
        check("t5_gap_no_wr", 64'(cov_wr), 64'(0));
        check("t5_gap_no_ww", 64'(cov_ww), 64'(0));
        do_tr(2'd2, 16'h0005, 32'h1, 32'h0, 1'b0, 32'd10);
        do_tr(2'd2, 16'h0005, 32'h2, 32'h0, 1'b0, 32'd11);
        check("t5_cov_ww", 64'(cov_ww), 64'(1));
        do_tr(2'd2, 16'h0005, 32'h9, 32'h0, 1'b0, 32'd20);
        do_tr(2'd1, 16'h0005, 32'h0, 32'h9, 1'b1, 32'd21);
        check("t5_cov_wr", 64'(cov_wr), 64'(1));

        hard_reset();
        do_tr(2'd2, 16'h0042, 32'h11, 32'h0, 1'b0, 32'hFFFF_FFFF);
        do_tr(2'd2, 16'h0042, 32'h22, 32'h0, 1'b0, 32'h0000_0000);
        check("t5_wrap_ww", 64'(cov_ww), 64'(1));

        hard_reset();
        tx(2'd2, 16'h0033, 32'h77, 32'h0, 1'b0);
        tx(2'd3, 16'h0033, 32'h0, 32'h0, 1'b0);
        check("t6_illegal", 64'(last_err), 64'(1));
        tx(2'd0, 16'h0000, 32'h0, 32'h0, 1'b0);
        tx(2'd1, 16'h0033, 32'h0, 32'h0, 1'b0);
        check("t6_after_reset_tr", 64'(last_err), 64'(0));
        for (int i = 0; i < ERR_MAX + 4; i++) tx(2'd3, KEY_W'(i), 32'h0, 32'h0, 1'b0);
        check("t6_saturate", 64'(err_count), 64'(ERR_MAX));

        // Abandoned transaction: rst during LOOKUP must suppress the commit.
        bus.tr_valid = 1'b1; bus.tr_type = 2'd3; bus.tr_key = 16'h0001;
        @(negedge clk);
        bus.tr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset_all();
        check("t6_rst_lookup_chk_valid", 64'(chk_valid), 64'(0));
        @(negedge clk);
        check("t6_rst_lookup_chk_valid2", 64'(chk_valid), 64'(0));
        check_idle_state("t6_rst_lookup");

        hard_reset();
        for (int n = 0; n < 400; n++) begin
            ty = 2'($urandom_range(0, 99) < 3 ? 0 : ($urandom_range(0, 99) < 5 ? 3 : $urandom_range(1, 2)));
            k = KEY_W'($urandom_range(0, 11));
            rd = $urandom;
            h = 1'($urandom);
            idx = find_key(k);
            if (ty == 2'd1 && idx >= 0 && $urandom_range(0, 3) != 0) begin
                rd = m_data[idx];
                h = 1'b1;
            end
            lt = lt + LTIME_W'($urandom_range(0, 3) == 0 ? 2 : 1);
            do_tr(ty, k, DATA_W'($urandom_range(0, 3)), rd, h, lt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
